// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types and helpers for the data memory load/store unit
package data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int unsigned size_bytes(size_e s);
    return 32'd1 << s;
  endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// rtl/data_mem_lsu_if.sv - request/response bus between the MEM stage and the data memory
interface data_mem_lsu_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [WIDTH-1:0]  req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering: store mask/shift, load extract/extend, alignment check
module lsu_align
  import data_mem_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int NB    = WIDTH / 8,
  localparam int LW    = $clog2(NB)
) (
  input  logic [LW-1:0]    lane,
  input  size_e            size,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] rdword,
  output logic [NB-1:0]    byte_en,
  output logic [WIDTH-1:0] wdata_sh,
  output logic [WIDTH-1:0] rdata_ext,
  output logic             misaligned
);

  int               nbits;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    byte_en   = '0;
    rdata_ext = '0;
    nbits     = 8 * int'(size_bytes(size));
    // an oversized field only occurs for an illegal size; the top flags that separately
    if (nbits > WIDTH) nbits = WIDTH;
    misaligned = (int'(lane) % int'(size_bytes(size))) != 0;
    wdata_sh   = wdata << (8 * int'(lane));
    shifted    = rdword >> (8 * int'(lane));
    for (int b = 0; b < NB; b++) begin
      byte_en[b] = (b >= int'(lane)) && (b < int'(lane) + nbits / 8);
    end
    for (int j = 0; j < WIDTH; j++) begin
      if (j < nbits) rdata_ext[j] = shifted[j];
      else           rdata_ext[j] = !is_unsigned && shifted[nbits-1];
    end
  end

endmodule

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - byte-addressed data memory with request/response handshake and latency
module data_mem_lsu
  import data_mem_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 512,
  parameter int ADDR_W    = 32,
  parameter int BASE_ADDR = 1000,
  parameter int LATENCY   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  data_mem_lsu_if.slave bus
);

  localparam int NB    = WIDTH / 8;
  localparam int LW    = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 4;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  size_e            size_q, size_d;
  logic             uns_q, uns_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] off;
  logic              in_range, size_ill;
  logic              sel_we, sel_uns, sel_err;
  size_e             sel_size;
  logic [LW-1:0]     sel_lane;
  logic [IDX_W-1:0]  sel_idx;
  logic [WIDTH-1:0]  sel_wdata;
  logic [NB-1:0]     byte_en;
  logic [WIDTH-1:0]  wdata_sh, rdata_ext;
  logic              misaligned, go_resp, mem_we;

  // In IDLE the access works from the live request so LATENCY=1 can complete on
  // the acceptance edge; later it works from the latched copy.
  always_comb begin
    off      = bus.req_addr - ADDR_W'(BASE_ADDR);
    in_range = (bus.req_addr >= ADDR_W'(BASE_ADDR)) && ((off >> LW) < ADDR_W'(DEPTH));
    size_ill = (WIDTH == 32) && (bus.req_size == 2'd3);
    if (state_q == IDLE) begin
      sel_we    = bus.req_we;
      sel_size  = size_e'(bus.req_size);
      sel_uns   = bus.req_unsigned;
      sel_lane  = bus.req_addr[LW-1:0];
      sel_idx   = off[LW +: IDX_W];
      sel_wdata = bus.req_wdata;
    end else begin
      sel_we    = we_q;
      sel_size  = size_q;
      sel_uns   = uns_q;
      sel_lane  = lane_q;
      sel_idx   = idx_q;
      sel_wdata = wdata_q;
    end
  end

  assign sel_err = (state_q == IDLE) ? (!in_range || misaligned || size_ill) : err_q;

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .lane        (sel_lane),
    .size        (sel_size),
    .is_unsigned (sel_uns),
    .wdata       (sel_wdata),
    .rdword      (mem_q[sel_idx]),
    .byte_en     (byte_en),
    .wdata_sh    (wdata_sh),
    .rdata_ext   (rdata_ext),
    .misaligned  (misaligned)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    go_resp     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = sel_we;
          size_d  = sel_size;
          uns_d   = sel_uns;
          lane_d  = sel_lane;
          idx_d   = sel_idx;
          wdata_d = sel_wdata;
          err_d   = sel_err;
          cnt_d   = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            go_resp = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          go_resp = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (go_resp) begin
      rsp_err_d   = sel_err;
      rsp_rdata_d = (sel_we || sel_err) ? '0 : rdata_ext;
    end
  end

  assign mem_we = go_resp && sel_we && !sel_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= SZ_B;
      uns_q       <= 1'b0;
      lane_q      <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (byte_en[b]) mem_q[sel_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
